vpu_cmd_dispatch: RTL and testbench
===================================

VPU_CMD_DISPATCH -- requirements
Module: vpu_cmd_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter CMD_WIDTH, default 128, command word width.
REQ-003 Parameter TIMEOUT, default 1024, max cycles to wait for cmd_done after acceptance.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_cmd  input  CMD_WIDTH  command from sequencer; [127:120] opcode, [119:112] subop, [111:97] vd/vs1/vs2.
REQ-007 in_valid  input  1  in_cmd valid.
REQ-008 in_ready  output  1  FIFO can accept; equals !full && !flush.
REQ-009 flush  input  1  discard all queued (not in-flight) commands.
REQ-010 cmd  output  CMD_WIDTH  registered command to vector_unit.
REQ-011 cmd_valid  output  1  cmd valid to vector_unit.
REQ-012 cmd_ready  input  1  vector_unit accepts cmd.
REQ-013 cmd_done  input  1  vector_unit finished current command.
REQ-014 busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-015 fifo_count  output  clog2(DEPTH+1)  queued entries.
REQ-016 retired_count  output  16  commands completed, wraps 0xFFFF->0.
REQ-017 bad_cmd  output  1  one-cycle pulse: non-VPU opcode dropped.
REQ-018 timeout_err  output  1  sticky: cmd_done not seen within TIMEOUT.

Function
REQ-019 Push occurs when in_valid && in_ready at a clock edge; FIFO is in-order, no bypass.
REQ-020 in_ready deasserts when fifo_count==DEPTH; push while full never occurs; pop of full FIFO reasserts in_ready the next cycle.
REQ-021 FSM states IDLE, ISSUE, WAIT_DONE; exactly one command in flight.
REQ-022 IDLE, FIFO non-empty, head[127:120]==8'h02: pop head, load cmd, assert cmd_valid, go ISSUE.
REQ-023 IDLE, FIFO non-empty, head opcode !=8'h02: pop head, pulse bad_cmd one cycle, stay IDLE; cmd/cmd_valid unchanged.
REQ-024 Latency: command pushed into empty FIFO at edge N drives cmd_valid=1 after edge N+1.
REQ-025 ISSUE: cmd and cmd_valid held stable until cmd_ready sampled 1; then cmd_valid=0 after that edge, go WAIT_DONE, timeout counter cleared.
REQ-026 ISSUE with cmd_ready and cmd_done both 1 on same edge: go IDLE directly, retire counted.
REQ-027 WAIT_DONE: cmd_done=1 -> go IDLE, retired_count+1; cmd_done in IDLE or ISSUE (without cmd_ready) ignored.
REQ-028 WAIT_DONE: counter reaches TIMEOUT without cmd_done -> set timeout_err, go IDLE, no retire count.
REQ-029 flush: fifo_count=0 after the edge; same-cycle push discarded (in_ready low); in-flight command completes normally.
REQ-030 Next issue from IDLE occurs no earlier than the cycle after retirement (min 1 IDLE cycle between commands).
REQ-031 Push and pop on same edge: fifo_count unchanged.

Reset
REQ-032 On rst: FSM=IDLE, FIFO empty, fifo_count=0, cmd=0, cmd_valid=0, retired_count=0, bad_cmd=0, timeout_err=0, busy=0; in_ready=1 the cycle after.
REQ-033 rst mid-operation abandons in-flight and queued commands; no retire counted.
REQ-034 timeout_err cleared only by rst.

Verification
REQ-035 Push one cmd (opcode 02, subop 03, vd=2, vs1=0, vs2=1); cmd_ready=1; cmd_done 3 cycles later -> cmd_valid high exactly 1 cycle, cmd matches, retired_count=1, busy=0.
REQ-036 Push 5 cmds with cmd_ready=0 -> in_ready low after 4 queued plus 1 in ISSUE (fifo_count=4); release ready/done -> all 5 retire in order, retired_count=5.
REQ-037 Push opcode 8'h01 then valid MUL -> bad_cmd one pulse, only MUL reaches cmd, retired_count=1.
REQ-038 Hold cmd_ready=0 for 10 cycles -> cmd/cmd_valid stable all 10 cycles; same-edge cmd_ready+cmd_done -> retire, IDLE.
REQ-039 Queue 3, flush while first in WAIT_DONE -> fifo_count=0, first retires, retired_count=1.
REQ-040 TIMEOUT=16, withhold cmd_done -> timeout_err=1 at cycle 16, stays 1 until rst; rst mid-ISSUE -> all outputs at reset values.

Source files
------------

// File: rtl/vpu_cmd_dispatch.sv
// vpu_cmd_dispatch: in-order command FIFO feeding a single-in-flight issue FSM
// with opcode filtering, retire counting and a done-timeout watchdog.
module vpu_cmd_dispatch #(
    parameter int DEPTH     = 4,
    parameter int CMD_WIDTH = 128,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CMD_WIDTH-1:0]         in_cmd,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [CMD_WIDTH-1:0]         cmd,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    input  logic                         cmd_done,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [15:0]                  retired_count,
    output logic                         bad_cmd,
    output logic                         timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT+1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT-1);
    localparam logic [7:0]    VPU_OP = 8'h02;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t                 r_state;
    logic [CMD_WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]          r_wptr, r_rptr;
    logic [CW-1:0]          r_count;
    logic [TW-1:0]          r_timer;
    logic [CMD_WIDTH-1:0]   r_cmd;
    logic                   r_cmd_valid, r_bad, r_terr;
    logic [15:0]            r_retired;

    logic                   w_push, w_pop, w_good;
    logic [CMD_WIDTH-1:0]   w_head;

    assign in_ready      = (r_count != FULL) && !flush;
    assign w_push        = in_valid && in_ready;
    assign w_head        = r_mem[r_rptr];
    // Popping is suppressed during flush so a flushed head is never issued.
    assign w_pop         = (r_state == IDLE) && (r_count != '0) && !flush;
    assign w_good        = w_head[CMD_WIDTH-1 -: 8] == VPU_OP;
    assign cmd           = r_cmd;
    assign cmd_valid     = r_cmd_valid;
    assign busy          = (r_state != IDLE) || (r_count != '0);
    assign fifo_count    = r_count;
    assign retired_count = r_retired;
    assign bad_cmd       = r_bad;
    assign timeout_err   = r_terr;

    always_ff @(posedge clk)
        if (w_push)
            r_mem[r_wptr] <= in_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_bad       <= 1'b0;
            r_terr      <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_bad <= w_pop && !w_good;
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
                r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
            case (r_state)
                IDLE:
                    if (w_pop && w_good) begin
                        r_cmd       <= w_head;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                ISSUE:
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_timer     <= '0;
                        r_retired   <= cmd_done ? r_retired + 16'd1 : r_retired;
                        r_state     <= cmd_done ? IDLE : WAIT_DONE;
                    end
                WAIT_DONE:
                    if (cmd_done) begin
                        r_retired <= r_retired + 16'd1;
                        r_state   <= IDLE;
                    end else if (r_timer == TLAST) begin
                        r_terr  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vpu_cmd_dispatch.sv
// tb_vpu_cmd_dispatch: directed vectors with hand-computed expectations.
module tb_vpu_cmd_dispatch;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_cmd;
    logic         in_valid, in_ready, flush;
    logic [127:0] cmd;
    logic         cmd_valid, cmd_ready, cmd_done, busy;
    logic [2:0]   fifo_count;
    logic [15:0]  retired_count;
    logic         bad_cmd, timeout_err;
    int           n_tot = 0;
    int           n_bad = 0;
    logic [127:0] c [5];

    vpu_cmd_dispatch #(.DEPTH(4), .CMD_WIDTH(128), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_done(cmd_done), .busy(busy), .fifo_count(fifo_count),
        .retired_count(retired_count), .bad_cmd(bad_cmd), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_cmd = '0; flush = 1'b0;
        cmd_ready = 1'b0; cmd_done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] mk(input logic [7:0] op, input logic [7:0] sub,
                                         input logic [4:0] vd, input logic [4:0] vs1,
                                         input logic [4:0] vs2);
        return {op, sub, vd, vs1, vs2, 97'd0};
    endfunction

    initial begin
        // Basic issue / retire and reset values
        do_reset();
        check("rst_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_count", fifo_count, 0);
        check("rst_retired", retired_count, 0);
        check("rst_busy", busy, 0);
        check("rst_bad", bad_cmd, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_ready", in_ready, 1);
        c[0] = mk(8'h02, 8'h03, 5'd2, 5'd0, 5'd1);
        in_cmd = c[0]; in_valid = 1'b1; cmd_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_count", fifo_count, 1);
        check("t1_nolat", cmd_valid, 0);
        check("t1_busy", busy, 1);
        step();
        check("t1_valid", cmd_valid, 1);
        check("t1_cmd", cmd, c[0]);
        check("t1_popped", fifo_count, 0);
        step();
        check("t1_onecyc", cmd_valid, 0);
        step();
        step();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        check("t1_retired", retired_count, 1);
        check("t1_idle", busy, 0);

        // Fill FIFO behind a stalled issue, then drain in order
        do_reset();
        for (int k = 0; k < 5; k++) begin
            c[k] = mk(8'h02, 8'(k + 16), 5'(k), 5'(k + 1), 5'(k + 2));
            in_cmd = c[k]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("t2_full_cnt", fifo_count, 4);
        check("t2_full_rdy", in_ready, 0);
        check("t2_head", cmd, c[0]);
        cmd_ready = 1'b1; cmd_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_ord%0d", k), cmd, c[k]);
            check($sformatf("t2_vld%0d", k), cmd_valid, 1);
            step();
            step();
            if (k == 0) begin
                check("t2_rdy_back", in_ready, 1);
                check("t2_cnt3", fifo_count, 3);
            end
        end
        cmd_ready = 1'b0; cmd_done = 1'b0;
        check("t2_retired", retired_count, 5);
        check("t2_idle", busy, 0);

        // Non-VPU opcode dropped ahead of a valid MUL
        do_reset();
        c[0] = mk(8'h01, 8'h00, 5'd1, 5'd1, 5'd1);
        c[1] = mk(8'h02, 8'h05, 5'd3, 5'd4, 5'd5);
        in_cmd = c[0]; in_valid = 1'b1;
        step();
        in_cmd = c[1];
        step();
        in_valid = 1'b0;
        check("t3_bad", bad_cmd, 1);
        check("t3_novalid", cmd_valid, 0);
        check("t3_nocmd", cmd, 0);
        step();
        check("t3_bad_pulse", bad_cmd, 0);
        check("t3_mul", cmd, c[1]);
        check("t3_valid", cmd_valid, 1);
        cmd_ready = 1'b1; cmd_done = 1'b1;
        step();
        cmd_ready = 1'b0; cmd_done = 1'b0;
        check("t3_retired", retired_count, 1);

        // Backpressure hold, then same-edge ready+done
        do_reset();
        c[0] = mk(8'h02, 8'h07, 5'd9, 5'd8, 5'd7);
        in_cmd = c[0]; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("t4_cmd%0d", k), cmd, c[0]);
            check($sformatf("t4_vld%0d", k), cmd_valid, 1);
        end
        cmd_ready = 1'b1; cmd_done = 1'b1;
        step();
        cmd_ready = 1'b0; cmd_done = 1'b0;
        check("t4_drop", cmd_valid, 0);
        check("t4_retired", retired_count, 1);
        check("t4_idle", busy, 0);

        // Flush while first command waits for done
        do_reset();
        cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            c[k] = mk(8'h02, 8'(k), 5'(k), 5'd0, 5'd0);
            in_cmd = c[k]; in_valid = 1'b1;
            step();
        end
        check("t5_cnt2", fifo_count, 2);
        in_cmd = mk(8'h02, 8'hEE, 5'd0, 5'd0, 5'd0);
        flush = 1'b1;
        #1;
        check("t5_flush_rdy", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t5_cnt0", fifo_count, 0);
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        check("t5_retired", retired_count, 1);
        step();
        step();
        check("t5_none", cmd_valid, 0);
        check("t5_idle", busy, 0);

        // Done timeout, stickiness, and reset mid-ISSUE
        do_reset();
        cmd_ready = 1'b1;
        in_cmd = mk(8'h02, 8'h01, 5'd1, 5'd2, 5'd3); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        for (int k = 1; k < 16; k++) step();
        check("t6_pre_to", timeout_err, 0);
        step();
        check("t6_to", timeout_err, 1);
        check("t6_to_idle", busy, 0);
        check("t6_to_noret", retired_count, 0);
        cmd_ready = 1'b0;
        in_cmd = mk(8'h02, 8'h09, 5'd4, 5'd5, 5'd6); in_valid = 1'b1;
        step();
        in_cmd = mk(8'h02, 8'h0A, 5'd4, 5'd5, 5'd6);
        step();
        in_valid = 1'b0;
        check("t6_sticky", timeout_err, 1);
        check("t6_issue", cmd_valid, 1);
        check("t6_queued", fifo_count, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_r_terr", timeout_err, 0);
        check("t6_r_valid", cmd_valid, 0);
        check("t6_r_cmd", cmd, 0);
        check("t6_r_count", fifo_count, 0);
        check("t6_r_busy", busy, 0);
        check("t6_r_ret", retired_count, 0);
        check("t6_r_rdy", in_ready, 1);
        step();
        step();
        check("t6_r_quiet", cmd_valid, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
